adc_fb_acq: RTL
===============

# adc_fb_acq

Serial-ADC front end for the inverter voltage loop. On each control-rate strobe it clocks one conversion out of an AD7476-style 12-bit SPI ADC and converts the code to a signed Q5.7 voltage. It drives the `volt_fb` input of the inverter controller. Offset and gain are applied in a two-stage arithmetic pipeline with saturation.

## Interface
Parameters:
- CLK_DIV, 2: SCLK half-period in `clk` cycles (≥1); SCLK period = 2·CLK_DIV.
- OFFSET, 2048: ADC code corresponding to 0 V (offset-binary).
- GAIN, 16384: signed 18-bit scale factor, fixed point with GAIN_FW fraction bits.
- GAIN_FW, 14: fraction bits of GAIN (default GAIN = 1.0; 1 LSB of ADC = 1 LSB of Q5.7).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- trig  in  1  one-cycle start strobe (control-rate enable, 100 kHz).
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- adc_sdo  in  1  ADC serial data. ADC launches it on SCLK falling; this block samples it on SCLK rising.
- volt_fb  out  12  signed Q5.7 feedback voltage; holds its value between updates.
- valid  out  1  one-cycle pulse when a frame completes.
- fmt_err  out  1  one-cycle pulse, coincident with `valid`, when any leading-zero bit is 1.
- busy  out  1  high while a frame is in progress.
- missed  out  1  one-cycle pulse when `trig` arrives while `busy`.

## Operation
- States: IDLE → LEAD → SHIFT → CALC → OUT → IDLE.
- IDLE: `trig`=1 → LEAD.
- LEAD:
  - `adc_cs_n`=0, `adc_sclk`=1 for CLK_DIV cycles, then → SHIFT.
- SHIFT:
  - 16 bits. Each bit is CLK_DIV cycles of SCLK low followed by CLK_DIV cycles of SCLK high.
  - `adc_sdo` is shifted MSB-first into a 16-bit register on the clock edge that drives SCLK 0→1.
  - A 4-bit bit counter and a half-period counter control the sequence.
  - After the high half of bit 15 → CALC, with `adc_cs_n`=1 and `adc_sclk`=1.
- Frame format: bits[15:12] are leading zeros; bits[11:0] are the code, MSB first.
- CALC:
  - diff = {1'b0,code} − OFFSET, 13-bit signed.
  - prod = diff × GAIN, 31-bit signed, registered.
- OUT:
  - v = prod >>> GAIN_FW, arithmetic shift, truncation toward −∞.
  - Saturate v to [−2048, +2047].
  - If bits[15:12]==0: update `volt_fb` and pulse `valid`.
  - Otherwise: pulse `valid` and `fmt_err`, and `volt_fb` keeps its previous value.
  - Next state → IDLE.
- `busy` = (state ≠ IDLE).
- `trig` while busy is ignored, the frame in progress is unaffected, and `missed` pulses in the same-cycle-registered output (one cycle later).
- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `volt_fb`=0, `valid`=0, `fmt_err`=0, `busy`=0, `missed`=0, state IDLE, counters 0.
- Reset mid-frame: immediate abort with the above values; no `valid` is produced for the aborted frame.

## Timing
- Edge 0 is the rising edge that samples `trig`=1 in IDLE.
- After edge 1: `adc_cs_n`=0, `busy`=1.
- After edge 1+CLK_DIV: `adc_sclk`=0.
- Bit k (k=0..15) is sampled at edge 1+CLK_DIV+(2k+1)·CLK_DIV; `adc_sclk`=1 after that edge.
- After edge 1+33·CLK_DIV: `adc_cs_n`=1 (CALC).
- After edge 2+33·CLK_DIV: state OUT.
- After edge 3+33·CLK_DIV: `volt_fb`/`valid`/`fmt_err` updated, `busy`=0.
  - `valid` lasts exactly one cycle.
- With CLK_DIV=2: latency 69 cycles, which is well inside the 1000-cycle control period.
- A `trig` at edge 3+33·CLK_DIV or later starts a new frame. Back-to-back frames are allowed, with zero idle cycles minimum.

## Test plan
- Default params, ADC model returns code 3328 (2048+1280) → `volt_fb`=+1280 (10.0 V) with `valid` after edge 69; `adc_cs_n` low for exactly 66 cycles; 16 SCLK rising edges.
- Codes 0 and 4095 → `volt_fb`=−2048 and +2047. GAIN=32768 with code 3328 → saturates to +2047. GAIN=8192 with code 2047 → −1 (floor of −0.5).
- `trig` pulsed at edges 10 and 40 of a frame → two `missed` pulses; the frame completes normally at edge 69 with the correct value.
- Frame with bit15=1 and code 2560 → `valid`+`fmt_err` at edge 69; `volt_fb` holds the previous +1280.
- `rst` asserted asynchronously at edge 30 → `adc_cs_n`=1, `adc_sclk`=1, `busy`=0 immediately; no `valid`. After release, a new `trig` gives a correct frame.
- CLK_DIV=1, 100 consecutive triggers spaced 36 cycles apart → 100 `valid` pulses, 0 `missed`, and `volt_fb` tracks a ramped ADC code exactly.

Source files
------------

// File: rtl/adc_fb_acq.sv
// ============================================================================
//  Module   : adc_fb_acq
//  Brief    : AD7476-style serial ADC capture with offset/gain scaling to a
//             saturated signed Q5.7 voltage-loop feedback sample.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_fb_acq #(
    parameter int CLK_DIV = 2,
    parameter int OFFSET  = 2048,
    parameter int GAIN    = 16384,
    parameter int GAIN_FW = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdo,
    output logic [11:0] volt_fb,
    output logic        valid,
    output logic        fmt_err,
    output logic        busy,
    output logic        missed
);

    localparam int c_HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_HW-1:0]   c_HALF_LAST = c_HW'(CLK_DIV - 1);
    localparam logic signed [12:0] c_OFFSET   = 13'(OFFSET);
    localparam logic signed [17:0] c_GAIN     = 18'(GAIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CALC  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             state_q;
    logic [c_HW-1:0]    half_q;
    logic [3:0]         bit_q;
    logic [15:0]        shift_q;
    logic signed [30:0] prod_q;
    logic               start_q;
    logic               cs_n_q;
    logic               sclk_q;
    logic [11:0]        volt_q;
    logic               valid_q;
    logic               fmt_err_q;
    logic               busy_q;
    logic               missed_q;

    logic               w_accept;
    logic signed [12:0] diff_d;
    logic signed [30:0] prod_d;
    logic signed [30:0] scaled_d;
    logic [11:0]        sat_d;

    // A trigger is latched one cycle before the frame starts; the OUT cycle
    // also accepts one so frames can run back to back.
    assign w_accept = trig && (((state_q == S_IDLE) && !start_q) || (state_q == S_OUT));

    always_comb begin
        diff_d   = $signed({1'b0, shift_q[11:0]}) - c_OFFSET;
        prod_d   = 31'(diff_d) * 31'(c_GAIN);
        scaled_d = prod_q >>> GAIN_FW;
        if (scaled_d > 31'sd2047) begin
            sat_d = 12'h7FF;
        end else if (scaled_d < -31'sd2048) begin
            sat_d = 12'h800;
        end else begin
            sat_d = scaled_d[11:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            half_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            prod_q    <= '0;
            start_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            volt_q    <= '0;
            valid_q   <= 1'b0;
            fmt_err_q <= 1'b0;
            busy_q    <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            fmt_err_q <= 1'b0;
            missed_q  <= trig && !w_accept;
            if (w_accept) begin
                start_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        start_q <= 1'b0;
                        state_q <= S_LEAD;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        half_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                S_LEAD: begin
                    if (half_q == c_HALF_LAST) begin
                        state_q <= S_SHIFT;
                        sclk_q  <= 1'b0;
                        half_q  <= '0;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (half_q == c_HALF_LAST) begin
                        half_q <= '0;
                        if (!sclk_q) begin
                            // Data is captured on the edge that raises SCLK.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[14:0], adc_sdo};
                        end else if (bit_q == 4'd15) begin
                            state_q <= S_CALC;
                            cs_n_q  <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 4'd1;
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                S_CALC: begin
                    prod_q  <= prod_d;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    if (shift_q[15:12] != 4'd0) begin
                        fmt_err_q <= 1'b1;
                    end else begin
                        volt_q <= sat_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign volt_fb  = volt_q;
    assign valid    = valid_q;
    assign fmt_err  = fmt_err_q;
    assign busy     = busy_q;
    assign missed   = missed_q;

endmodule

`default_nettype wire
